// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//
// Carries branch records from the D stage through E and M pipeline registers.
// When a branch reaches M, it compares the predicted direction with the
// resolved direction. A mispredict raises a one-cycle recovery pulse and
// supplies the corrected fetch address. It then squashes the wrong-path
// E and M entries and spends one cycle in FLUSH before resuming detection.
//
// Optional feature (macro BRANCH_STATS_EN):
//   defined   -> branch_cnt / miss_cnt are saturating event counters
//   undefined -> no counter logic; both outputs are tied to 0
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   branchD        in   D-stage instruction is a branch
//   pred_takeD     in   predictor decision for the D-stage branch
//   pcD            in   D-stage PC
//   immD           in   sign-extended branch offset (in words)
//   actual_takeE   in   branch condition resolved in EX
//   stallE         in   hold the E register
//   stallM         in   hold the M register
//   flushE         in   insert a bubble into E
//   branchM        out  M-stage branch flag (forced 0 during FLUSH)
//   pred_takeM     out  M-stage predicted direction
//   actual_takeM   out  M-stage resolved direction
//   pcM            out  M-stage branch PC
//   mispredict     out  one-cycle mispredict pulse
//   redirect_valid out  one-cycle redirect pulse (same as mispredict)
//   redirect_pc    out  corrected fetch address, stable between redirects
//   branch_cnt     out  resolved-branch count (BRANCH_STATS_EN)
//   miss_cnt       out  mispredict count (BRANCH_STATS_EN)
// ---------------------------------------------------------------------------
module branch_resolve #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branchD,
    input  logic        pred_takeD,
    input  logic [31:0] pcD,
    input  logic [31:0] immD,
    input  logic        actual_takeE,
    input  logic        stallE,
    input  logic        stallM,
    input  logic        flushE,
    output logic        branchM,
    output logic        pred_takeM,
    output logic        actual_takeM,
    output logic [31:0] pcM,
    output logic        mispredict,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;

    // E-stage record
    logic        e_branch;
    logic        e_pred;
    logic [31:0] e_pc;
    logic [31:0] e_target;

    // M-stage record
    logic        m_branch;
    logic        m_pred;
    logic        m_actual;
    logic [31:0] m_pc;
    logic [31:0] m_target;

    logic [31:0] redirect_q;
    logic [31:0] target_d;
    logic        resolve;
    logic        miss;
    logic        squash;
    logic [31:0] fix_pc;

    // Taken target, wrapping modulo 2^32.
    assign target_d = pcD + 32'd4 + (immD << 2);

    // A branch resolves once, on the first cycle it sits in M un-stalled.
    // In FLUSH the M entry belongs to the squashed wrong path, so it is ignored.
    assign resolve = (state == RUN) && m_branch && !stallM;
    assign miss    = m_pred ^ m_actual;
    assign squash  = resolve && miss;

    // Not-taken recovery skips the branch and its delay slot.
    assign fix_pc  = m_actual ? m_target : (m_pc + 32'd8);

    // ------------------------------------------------------------------
    // E register
    // ------------------------------------------------------------------
    // NOTE: Sequential state uses non-blocking assignments. Every register
    // then samples its inputs from before the edge, whatever the order of
    // the always_ff blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_branch <= 1'b0;
            e_pred   <= 1'b0;
            e_pc     <= 32'd0;
            e_target <= 32'd0;
        end else begin
            if (!stallE) begin
                e_pred   <= pred_takeD;
                e_pc     <= pcD;
                e_target <= target_d;
            end
            // The mispredict squash wins over both hold and capture.
            if (squash) begin
                e_branch <= 1'b0;
            end else if (!stallE) begin
                e_branch <= branchD && !flushE;
            end
        end
    end

    // ------------------------------------------------------------------
    // M register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_branch <= 1'b0;
            m_pred   <= 1'b0;
            m_actual <= 1'b0;
            m_pc     <= 32'd0;
            m_target <= 32'd0;
        end else begin
            if (!stallM) begin
                m_pred   <= e_pred;
                m_actual <= actual_takeE;
                m_pc     <= e_pc;
                m_target <= e_target;
            end
            if (squash) begin
                m_branch <= 1'b0;
            end else if (!stallM) begin
                m_branch <= e_branch;
            end
        end
    end

    // ------------------------------------------------------------------
    // Recovery FSM and registered redirect address
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            redirect_q <= RESET_PC;
        end else begin
            case (state)
                RUN: begin
                    if (squash) begin
                        state      <= FLUSH;
                        redirect_q <= fix_pc;
                    end
                end
                FLUSH: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // The pulse and the corrected address appear in the detect cycle itself.
    // The registered copy then holds that address until the next redirect.
    assign mispredict     = squash;
    assign redirect_valid = squash;
    assign redirect_pc    = squash ? fix_pc : redirect_q;

    assign branchM      = m_branch && (state == RUN);
    assign pred_takeM   = m_pred;
    assign actual_takeM = m_actual;
    assign pcM          = m_pc;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef BRANCH_STATS_EN
    logic [31:0] branch_q;
    logic [31:0] miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_q <= 32'd0;
            miss_q   <= 32'd0;
        end else begin
            if (resolve && (branch_q != 32'hFFFF_FFFF)) begin
                branch_q <= branch_q + 32'd1;
            end
            if (squash && (miss_q != 32'hFFFF_FFFF)) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign branch_cnt = branch_q;
    assign miss_cnt   = miss_q;
`else
    assign branch_cnt = 32'd0;
    assign miss_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve
//
// Directed bench for branch_resolve. A table of single-branch vectors is
// pushed through D->E->M. Each vector is checked in its resolve cycle and in
// the two cycles that follow. Hand-written sequences then cover the M stall,
// flushE, wrong-path squash of E, and reset during FLUSH.
// The expected counter values depend on BRANCH_STATS_EN.
// ---------------------------------------------------------------------------
module tb_branch_resolve;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst_n;
    logic        branchD;
    logic        pred_takeD;
    logic [31:0] pcD;
    logic [31:0] immD;
    logic        actual_takeE;
    logic        stallE;
    logic        stallM;
    logic        flushE;
    logic        branchM;
    logic        pred_takeM;
    logic        actual_takeM;
    logic [31:0] pcM;
    logic        mispredict;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the statistics counters
    int exp_branches = 0;
    int exp_misses   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        act;
        logic        exp_miss;
        logic [31:0] exp_redirect;
    } vec_t;

    vec_t vecs [6];

    branch_resolve #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .branchD        (branchD),
        .pred_takeD     (pred_takeD),
        .pcD            (pcD),
        .immD           (immD),
        .actual_takeE   (actual_takeE),
        .stallE         (stallE),
        .stallM         (stallM),
        .flushE         (flushE),
        .branchM        (branchM),
        .pred_takeM     (pred_takeM),
        .actual_takeM   (actual_takeM),
        .pcM            (pcM),
        .mispredict     (mispredict),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_cnt     (branch_cnt),
        .miss_cnt       (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name);
`ifdef BRANCH_STATS_EN
        check({name, " branch_cnt"}, branch_cnt, exp_branches);
        check({name, " miss_cnt"},   miss_cnt,   exp_misses);
`else
        check({name, " branch_cnt"}, branch_cnt, 32'd0);
        check({name, " miss_cnt"},   miss_cnt,   32'd0);
`endif
    endtask

    // Advance past the next rising edge. Inputs change 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_branch(input logic [31:0] pc, input logic [31:0] imm,
                                input logic pred, input logic act);
        branchD      = 1'b1;
        pcD          = pc;
        immD         = imm;
        pred_takeD   = pred;
        actual_takeE = act;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        step();
        drive_branch(v.pc, v.imm, v.pred, v.act);
        step();                 // branch now in E
        branchD = 1'b0;
        step();                 // branch now in M
        @(negedge clk);
        check({tag, " branchM"},      {31'd0, branchM},        32'd1);
        check({tag, " pcM"},          pcM,                     v.pc);
        check({tag, " pred_takeM"},   {31'd0, pred_takeM},     {31'd0, v.pred});
        check({tag, " actual_takeM"}, {31'd0, actual_takeM},   {31'd0, v.act});
        check({tag, " mispredict"},   {31'd0, mispredict},     {31'd0, v.exp_miss});
        check({tag, " redirect_vld"}, {31'd0, redirect_valid}, {31'd0, v.exp_miss});
        check({tag, " redirect_pc"},  redirect_pc,             v.exp_redirect);
        exp_branches++;
        if (v.exp_miss) exp_misses++;
        step();                 // FLUSH after a miss, otherwise RUN
        @(negedge clk);
        check({tag, " +1 branchM"},     {31'd0, branchM},    32'd0);
        check({tag, " +1 mispredict"},  {31'd0, mispredict}, 32'd0);
        check({tag, " +1 redirect_pc"}, redirect_pc,         v.exp_redirect);
        check_cnt({tag, " +1"});
        step();
        @(negedge clk);
        check({tag, " +2 branchM"},    {31'd0, branchM},    32'd0);
        check({tag, " +2 mispredict"}, {31'd0, mispredict}, 32'd0);
    endtask

    initial begin
        // A missed prediction moves redirect_pc. A correct one leaves the previous value.
        vecs[0] = '{32'h0000_0100, 32'd4,          1'b1, 1'b1, 1'b0, RST_PC};
        vecs[1] = '{32'h0000_0100, 32'd4,          1'b1, 1'b0, 1'b1, 32'h0000_0108};
        vecs[2] = '{32'h0000_0200, 32'hFFFF_FFFE,  1'b0, 1'b1, 1'b1, 32'h0000_01FC};
        vecs[3] = '{32'hFFFF_FFF8, 32'd2,          1'b0, 1'b1, 1'b1, 32'h0000_0004};
        vecs[4] = '{32'h0000_0400, 32'd7,          1'b0, 1'b0, 1'b0, 32'h0000_0004};
        vecs[5] = '{32'h0000_0500, 32'd9,          1'b1, 1'b0, 1'b1, 32'h0000_0508};

        rst_n        = 1'b0;
        branchD      = 1'b0;
        pred_takeD   = 1'b0;
        pcD          = 32'd0;
        immD         = 32'd0;
        actual_takeE = 1'b0;
        stallE       = 1'b0;
        stallM       = 1'b0;
        flushE       = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst branchM",     {31'd0, branchM},        32'd0);
        check("rst mispredict",  {31'd0, mispredict},     32'd0);
        check("rst redirect_vld",{31'd0, redirect_valid}, 32'd0);
        check("rst pcM",         pcM,                     32'd0);
        check("rst redirect_pc", redirect_pc,             RST_PC);
        check_cnt("rst");
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // The mispredict is held in M by stallM for three cycles. It fires once, on release.
        step();
        drive_branch(32'h0000_0300, 32'd1, 1'b1, 1'b0);
        step();
        branchD = 1'b0;
        step();
        stallM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d mispredict", k), {31'd0, mispredict}, 32'd0);
            check($sformatf("stall%0d branchM", k),    {31'd0, branchM},    32'd1);
            check_cnt($sformatf("stall%0d", k));
            step();
        end
        stallM = 1'b0;
        @(negedge clk);
        check("stall rel mispredict",  {31'd0, mispredict}, 32'd1);
        check("stall rel redirect_pc", redirect_pc,         32'h0000_0308);
        exp_branches++;
        exp_misses++;
        step();
        @(negedge clk);
        check("stall post mispredict", {31'd0, mispredict}, 32'd0);
        check("stall post branchM",    {31'd0, branchM},    32'd0);
        check_cnt("stall post");
        step();

        // flushE turns a would-be mispredict into a bubble.
        step();
        drive_branch(32'h0000_0600, 32'd3, 1'b1, 1'b0);
        flushE = 1'b1;
        step();
        branchD = 1'b0;
        flushE  = 1'b0;
        step();
        @(negedge clk);
        check("flushE branchM",     {31'd0, branchM},    32'd0);
        check("flushE mispredict",  {31'd0, mispredict}, 32'd0);
        check("flushE redirect_pc", redirect_pc,         32'h0000_0308);
        check_cnt("flushE");

        // A wrong-path branch sitting in D during the mispredict is squashed in E.
        step();
        drive_branch(32'h0000_0700, 32'd3, 1'b0, 1'b1);
        step();                 // A in E
        pcD = 32'h0000_0800;    // wrong-path branch B in D
        step();                 // A in M, B in E
        pcD = 32'h0000_0900;    // wrong-path branch C in D
        @(negedge clk);
        check("squash A mispredict",  {31'd0, mispredict}, 32'd1);
        check("squash A redirect_pc", redirect_pc,         32'h0000_0710);
        exp_branches++;
        exp_misses++;
        step();                 // FLUSH; E and M were squashed
        branchD = 1'b0;
        @(negedge clk);
        check("squash flush branchM", {31'd0, branchM}, 32'd0);
        step();                 // RUN; M holds the squashed C
        @(negedge clk);
        check("squash C branchM",    {31'd0, branchM},    32'd0);
        check("squash C mispredict", {31'd0, mispredict}, 32'd0);
        check_cnt("squash");
        step();

        // Reset asserted during FLUSH aborts the recovery.
        step();
        drive_branch(32'h0000_0A00, 32'd1, 1'b1, 1'b0);
        step();
        branchD = 1'b0;
        step();
        @(negedge clk);
        check("rstf mispredict", {31'd0, mispredict}, 32'd1);
        step();                 // FLUSH
        #1 rst_n = 1'b0;
        #1;
        exp_branches = 0;
        exp_misses   = 0;
        check("rstf redirect_pc", redirect_pc,         RST_PC);
        check("rstf mispredict",  {31'd0, mispredict}, 32'd0);
        check("rstf branchM",     {31'd0, branchM},    32'd0);
        check_cnt("rstf");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            check($sformatf("rstf post%0d mispredict", k), {31'd0, mispredict}, 32'd0);
            check($sformatf("rstf post%0d redirect_pc", k), redirect_pc, RST_PC);
        end

        // Normal capture resumes after reset.
        run_vec(6, '{32'h0000_0B00, 32'd0, 1'b1, 1'b1, 1'b0, RST_PC});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'hBFC0_0000, giving the value of redirect_pc after reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports branchD, pred_takeD  in  1 each  D-stage branch flag and predictor decision.
REQ-005 SHALL have ports pcD, immD  in  32 each  D-stage PC and sign-extended branch offset.
REQ-006 SHALL have port actual_takeE  in  1  branch condition result evaluated in EX.
REQ-007 SHALL have ports stallE, stallM, flushE  in  1 each  pipeline hold and bubble controls.
REQ-008 SHALL have ports branchM, pred_takeM, actual_takeM  out  1 each  M-stage record for predictor training.
REQ-009 SHALL have port pcM  out  32  M-stage branch PC for predictor training.
REQ-010 SHALL have ports mispredict, redirect_valid  out  1 each  single-cycle recovery pulses.
REQ-011 SHALL have port redirect_pc  out  32  corrected fetch address.
REQ-012 SHALL have ports branch_cnt, miss_cnt  out  32 each  statistics counters.

Function
REQ-013 SHALL compute targetD = pcD + 4 + (immD << 2), mod 2^32, with wrap-around permitted.
REQ-014 SHALL capture {branchD, pred_takeD, pcD, targetD} into the E register on each clk edge when stallE=0.
REQ-015 SHALL hold the E register when stallE=1.
REQ-016 SHALL clear the E register's branch flag when flushE=1 and stallE=0; flushE SHALL take precedence over capture.
REQ-017 SHALL capture the E record plus actual_takeE into the M register when stallM=0, giving D-to-M latency of 2 un-stalled cycles.
REQ-018 SHALL hold the M register when stallM=1.
REQ-019 SHALL implement a two-state FSM {RUN, FLUSH}.
REQ-020 In RUN, SHALL detect a resolution event when branchM=1 and stallM=0, and SHALL evaluate miss = pred_takeM XOR actual_takeM.
REQ-021 On a resolution event with miss=1 in RUN, SHALL assert mispredict=1 and redirect_valid=1 for exactly one cycle, combinationally in the detect cycle.
REQ-022 SHALL drive redirect_pc = targetM when actual_takeM=1, else pcM + 8 (delay-slot fall-through).
REQ-023 SHALL register redirect_pc so that it stays stable until the next redirect.
REQ-024 After a mispredict, SHALL enter FLUSH on the next edge and clear the E and M branch flags at that edge, squashing the wrong path.
REQ-025 In FLUSH, SHALL suppress all detection and counting, and SHALL return to RUN after one cycle.
REQ-026 SHALL expose branchM, pred_takeM, actual_takeM and pcM directly from the M register.
REQ-027 SHALL force branchM=0 while in FLUSH, so the predictor is never trained on squashed entries.
REQ-028 With stallM=1 and branchM=1, SHALL produce no event; the event SHALL fire once, on the first un-stalled cycle.
REQ-029 When flushE and a mispredict occur in the same cycle, SHALL take the mispredict squash; the result SHALL be E cleared.

Reset
REQ-030 On rst_n=0, SHALL asynchronously reset all registered state: pipeline valid bits 0, FSM=RUN, redirect_pc=RESET_PC, counters 0.
REQ-031 During reset, SHALL hold all outputs at 0 except redirect_pc.
REQ-032 Reset asserted mid-FLUSH SHALL abort recovery, with no pulse emitted after reset release.
REQ-033 SHALL resume normal capture on the first edge after rst_n rises.

Configuration
REQ-034 With macro BRANCH_STATS_EN defined, branch_cnt SHALL increment on every resolution event and miss_cnt on every mispredict.
REQ-035 With BRANCH_STATS_EN defined, both counters SHALL saturate at 32'hFFFF_FFFF.
REQ-036 Without BRANCH_STATS_EN, no counter logic SHALL be built, and branch_cnt and miss_cnt SHALL be tied to 0.

Verification
REQ-037 Bench SHALL cover: pcD=0x100, immD=4, pred_takeD=1, actual_takeE=1 -> branchM=1 and pcM=0x100 two cycles later, mispredict=0.
REQ-038 Bench SHALL cover: pcD=0x100, immD=4, pred_takeD=1, actual_takeE=0 -> mispredict=1 for one cycle, redirect_pc=0x108, then FLUSH with branchM=0 for one cycle.
REQ-039 Bench SHALL cover: pcD=0x200, immD=-2, pred_takeD=0, actual_takeE=1 -> redirect_pc=0x1FC.
REQ-040 Bench SHALL cover: mispredict in M held by stallM=1 for 3 cycles -> a single mispredict pulse on release, and miss_cnt +1 (with BRANCH_STATS_EN).
REQ-041 Bench SHALL cover: pcD=0xFFFF_FFF8, immD=2, taken mispredicted -> redirect_pc=0x0000_0004 (wrap).
REQ-042 Bench SHALL cover: rst_n pulsed low during FLUSH -> redirect_pc=RESET_PC, mispredict=0, counters 0.
